// File: rtl/pingpong_frame_ctrl.sv
// Double-buffered frame controller: one bank fills from the ADC stream while the
// other streams a complete frame to the DSP core over valid/ready.
module pingpong_frame_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            bank_full,
  output logic [CNT_WIDTH-1:0]  overrun_cnt,
  output logic [CNT_WIDTH-1:0]  frames_done
);
  localparam int PW = $clog2(FRAME_LEN);
  localparam logic [PW-1:0] PTR_MAX = PW'(FRAME_LEN - 1);

  localparam logic [0:0] W_FILL   = 1'b0;
  localparam logic [0:0] W_WAIT   = 1'b1;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_STREAM = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [2][FRAME_LEN];

  logic [0:0]           wstate_q, wstate_d, rstate_q, rstate_d;
  logic                 wsel_q, wsel_d, rsel_q, rsel_d;
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]           full_q, full_d;
  logic [CNT_WIDTH-1:0] ovr_q, ovr_d, frames_q, frames_d;
  logic                 in_xfer, out_xfer, wr_last, rd_last;

  assign in_ready    = (wstate_q == W_FILL);
  assign out_valid   = (rstate_q == R_STREAM);
  assign out_data    = mem_q[rsel_q][rptr_q];
  assign out_last    = out_valid && (rptr_q == PTR_MAX);
  assign bank_full   = full_q;
  assign overrun_cnt = ovr_q;
  assign frames_done = frames_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign wr_last  = in_xfer && (wptr_q == PTR_MAX);
  assign rd_last  = out_xfer && (rptr_q == PTR_MAX);

  always_comb begin
    wstate_d = wstate_q;
    rstate_d = rstate_q;
    wsel_d   = wsel_q;
    rsel_d   = rsel_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    full_d   = full_q;
    ovr_d    = ovr_q;
    frames_d = frames_q;

    // Writer decides on the registered full flag of the other bank, so a bank
    // freed in the same cycle costs exactly one W_WAIT bubble.
    case (wstate_q)
      W_FILL: if (in_xfer) begin
        wptr_d = wr_last ? '0 : wptr_q + 1'b1;
        if (wr_last) begin
          full_d[wsel_q] = 1'b1;
          if (!full_q[~wsel_q]) wsel_d   = ~wsel_q;
          else                  wstate_d = W_WAIT;
        end
      end
      default: if (!full_q[~wsel_q]) begin
        wsel_d   = ~wsel_q;
        wstate_d = W_FILL;
      end
    endcase

    case (rstate_q)
      R_IDLE: if (full_q[rsel_q]) rstate_d = R_STREAM;
      default: if (out_xfer) begin
        rptr_d = rptr_q + 1'b1;
        if (rd_last) begin
          full_d[rsel_q] = 1'b0;
          rsel_d         = ~rsel_q;
          rptr_d         = '0;
          frames_d       = frames_q + 1'b1;
          rstate_d       = R_IDLE;
        end
      end
    endcase

    if (in_valid && !in_ready && (ovr_q != '1)) ovr_d = ovr_q + 1'b1;

    if (flush) begin
      wstate_d = W_FILL;
      rstate_d = R_IDLE;
      wsel_d   = 1'b0;
      rsel_d   = 1'b0;
      wptr_d   = '0;
      rptr_d   = '0;
      full_d   = '0;
      ovr_d    = '0;
      frames_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q <= W_FILL;
      rstate_q <= R_IDLE;
      wsel_q   <= 1'b0;
      rsel_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      full_q   <= '0;
      ovr_q    <= '0;
      frames_q <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      wsel_q   <= wsel_d;
      rsel_q   <= rsel_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      full_q   <= full_d;
      ovr_q    <= ovr_d;
      frames_q <= frames_d;
    end
  end

  // Bank storage is never cleared; full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (in_xfer && !flush) mem_q[wsel_q][wptr_q] <= in_data;
  end

endmodule

// File: doc/pingpong_frame_ctrl.md
Name: pingpong_frame_ctrl

Overview:
- Double-buffered (ping-pong) frame controller between the ADC sample stream and the DSP core.
- Incoming samples fill one bank of FRAME_LEN words while the other bank streams a complete frame to the DSP core over a valid/ready interface.
- Sequences bank ownership, back-pressures the source when both banks are occupied, counts lost input cycles, and supports a synchronous flush.

Parameters:
DATA_WIDTH, 16, sample width in bits
FRAME_LEN, 256, samples per frame/bank (power of two, >=4)
CNT_WIDTH, 16, width of the overrun counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort: discard both banks, return to reset state
in_valid  input  1  source sample valid
in_ready  output  1  controller accepts sample this cycle
in_data  input  DATA_WIDTH  source sample
out_valid  output  1  sample available to DSP core
out_ready  input  1  DSP core accepts sample
out_data  output  DATA_WIDTH  sample bank[rsel][rptr]
out_last  output  1  high with final sample of a frame
bank_full  output  2  per-bank full flags
overrun_cnt  output  CNT_WIDTH  saturating count of cycles with in_valid=1, in_ready=0
frames_done  output  CNT_WIDTH  wrapping count of frames fully streamed out

Behaviour:
- Reset (async) and flush (sync, priority over all other activity) do the following:
  - Clear wsel, rsel, wptr, rptr, bank_full, overrun_cnt and frames_done.
  - Write FSM goes to W_FILL; read FSM goes to R_IDLE.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_data=bank[0][0] (contents undefined).
  - Bank storage is not cleared.
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid, once high, holds with stable out_data until accepted.
- Write FSM, W_FILL (in_ready=1):
  - On each input transfer: bank[wsel][wptr] <= in_data; wptr++.
  - On the transfer with wptr==FRAME_LEN-1:
    - bank_full[wsel] <= 1; wptr <= 0.
    - If bank_full[~wsel]==0 (registered value): wsel toggles and stay in W_FILL.
    - Else go to W_WAIT.
- Write FSM, W_WAIT (in_ready=0):
  - When bank_full[~wsel]==0: wsel toggles, go to W_FILL (in_ready high the next cycle).
- Read FSM, R_IDLE (out_valid=0):
  - If bank_full[rsel]==1, go to R_STREAM next cycle.
  - Latency: first out_valid appears 2 cycles after the final write of a bank.
- Read FSM, R_STREAM (out_valid=1):
  - out_data = bank[rsel][rptr] (combinational array read); out_last = (rptr==FRAME_LEN-1).
  - On each output transfer: rptr++.
  - On the last transfer: bank_full[rsel] <= 0, rsel toggles, rptr <= 0, frames_done++, go to R_IDLE.
- Simultaneous events:
  - If the read side frees a bank in the same cycle the write side completes the other bank, the write FSM still enters W_WAIT and returns to W_FILL the next cycle. This is exactly one bubble cycle with in_ready=0.
  - Set and clear of bank_full never target the same bank in the same cycle; the reader only clears a bank it owns, the writer only sets the bank it fills.
- Counters:
  - overrun_cnt increments on every cycle with in_valid=1 and in_ready=0, saturating at all-ones.
  - frames_done wraps modulo 2^CNT_WIDTH.
- Frame order: strictly FIFO. Bank 0 is filled and streamed first, then banks alternate.
- No partial frames are ever streamed. A reset or flush mid-frame discards the partial frame; streaming restarts at bank 0, index 0.
- Pointers are $clog2(FRAME_LEN) bits and cannot exceed FRAME_LEN-1.

Test Plan:
1. Reset, then 256 samples 0..255 with in_valid held high and out_ready=1 -> bank_full=01 after the 256th transfer; out_valid rises 2 cycles later; outputs 0..255 in order with out_last only on 255; frames_done=1; overrun_cnt=0.
2. Continuous input 0..767 with out_ready=0 -> banks 0 and 1 fill (bank_full=11); in_ready drops after sample 511; overrun_cnt counts 1 per stalled cycle. Then release out_ready -> frame 0..255 streams, in_ready returns 1 cycle after bank 0 frees, and 512..767 land in bank 0.
3. out_ready toggled every cycle during streaming -> out_data stable while out_valid=1 and out_ready=0; sequence intact; the 256 transfers take 512 cycles.
4. Writer completes bank 1 on the same cycle the reader's last transfer frees bank 0 -> exactly one in_ready=0 bubble; subsequent samples go to bank 0; no data lost.
5. Flush asserted after 100 samples of the second frame, while the first frame is mid-stream at rptr=40 -> next cycle out_valid=0, in_ready=1, bank_full=00, counters 0; new samples are written to bank 0 index 0 and stream first.
6. Hold in_valid=1 with out_ready=0 for more than 65536 stalled cycles -> overrun_cnt saturates at 16'hFFFF; an async reset pulse mid-stream clears all outputs immediately.
